// File: rtl/slc3_step_ctrl_if.sv
// CPU-side handshake between the SLC-3 control FSM and the front-panel step controller.
interface slc3_step_ctrl_if;
    logic        pause_req;
    logic [11:0] pause_code;
    logic        start;
    logic        resume;
    logic [11:0] LED;
    logic        running;
    logic        paused;

    modport master (
        output pause_req, pause_code,
        input  start, resume, LED, running, paused
    );

    modport slave (
        input  pause_req, pause_code,
        output start, resume, LED, running, paused
    );
endinterface

// File: rtl/slc3_step_ctrl.sv
// Front-panel Run/Continue controller: synchronises and debounces the active-low
// buttons, issues one-cycle start/resume pulses and latches the pause code for LED.
module slc3_step_ctrl #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             Continue,
    slc3_step_ctrl_if.slave  bus
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, START, RUNNING, PAUSED, RESUME, WAIT_ACK
    } state_t;

    state_t state, state_next;
    logic   led_load;
    logic [11:0] led_q;

    logic [SYNC_STAGES-1:0] sync_run, sync_cont, sync_vld;
    logic [1:0]             synced;      // [0] Run, [1] Continue
    logic [1:0]             level;       // accepted (debounced) level, 1 = released
    logic [1:0]             armed;       // a release has been seen since reset
    logic [1:0]             press_ev;    // one-cycle press events
    logic [CW-1:0]          cnt [2];

    assign synced = {sync_cont[SYNC_STAGES-1], sync_run[SYNC_STAGES-1]};

    // Button synchronisers; sync_vld marks when the chain holds real pin samples after reset.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            sync_run  <= '1;
            sync_cont <= '1;
            sync_vld  <= '0;
        end else begin
            sync_run  <= {sync_run[SYNC_STAGES-2:0], Run};
            sync_cont <= {sync_cont[SYNC_STAGES-2:0], Continue};
            sync_vld  <= {sync_vld[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Debounce and press-event detection. A button is only armed once a released sample
    // has come through the chain, so a button held across reset cannot raise an event.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            level    <= '1;
            armed    <= '0;
            press_ev <= '0;
            for (int unsigned b = 0; b < 2; b++) cnt[b] <= '0;
        end else begin
            press_ev <= '0;
            if (sync_vld[SYNC_STAGES-1]) begin
                for (int unsigned b = 0; b < 2; b++) begin
                    if (!armed[b]) begin
                        cnt[b] <= '0;
                        if (synced[b]) armed[b] <= 1'b1;
                    end else if (synced[b] == level[b]) begin
                        cnt[b] <= '0;
                    end else if (cnt[b] == CNT_LAST) begin
                        level[b]    <= synced[b];
                        cnt[b]      <= '0;
                        press_ev[b] <= ~synced[b];
                    end else begin
                        cnt[b] <= cnt[b] + 1'b1;
                    end
                end
            end
        end
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (!Reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic; events arriving in states that do not consume them are dropped.
    always_comb begin
        state_next = state;
        led_load   = 1'b0;
        unique case (state)
            IDLE:     if (press_ev[0]) state_next = START;
            START:    state_next = RUNNING;
            RUNNING:  if (bus.pause_req) begin
                          state_next = PAUSED;
                          led_load   = 1'b1;
                      end
            PAUSED:   if (press_ev[1]) state_next = RESUME;
            RESUME:   state_next = WAIT_ACK;
            WAIT_ACK: if (!bus.pause_req) state_next = RUNNING;
            default:  state_next = IDLE;
        endcase
    end

    // Pause-code latch, loaded on pause entry only.
    always_ff @(posedge Clk) begin
        if (!Reset)        led_q <= '0;
        else if (led_load) led_q <= bus.pause_code;
    end

    assign bus.start   = (state == START);
    assign bus.resume  = (state == RESUME);
    assign bus.running = (state == RUNNING) || (state == WAIT_ACK);
    assign bus.paused  = (state == PAUSED);
    assign bus.LED     = led_q;

endmodule

// File: tb/tb_slc3_step_ctrl.sv
// Directed bench for slc3_step_ctrl at default parameters plus a DEBOUNCE_CYCLES=4 instance.
module tb_slc3_step_ctrl;

    logic Clk;
    logic Reset;
    logic Run, Continue;
    logic Run4;

    int n_chk  = 0;
    int n_fail = 0;
    int n_start, n_resume, n_start4;

    slc3_step_ctrl_if cpu ();
    slc3_step_ctrl_if cpu4 ();

    slc3_step_ctrl #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)) u_dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Run      (Run),
        .Continue (Continue),
        .bus      (cpu.slave)
    );

    slc3_step_ctrl #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) u_dut4 (
        .Clk      (Clk),
        .Reset    (Reset),
        .Run      (Run4),
        .Continue (1'b1),
        .bus      (cpu4.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Advance n cycles, counting output pulses of both instances.
    task automatic run_count(input int n);
        n_start  = 0;
        n_resume = 0;
        n_start4 = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (cpu.start)  n_start++;
            if (cpu.resume) n_resume++;
            if (cpu4.start) n_start4++;
        end
    endtask

    initial begin
        Reset = 1'b0;
        Run = 1'b1; Continue = 1'b1; Run4 = 1'b1;
        cpu.pause_req = 1'b0;  cpu.pause_code = 12'h000;
        cpu4.pause_req = 1'b0; cpu4.pause_code = 12'h000;

        // Test 1: reset state
        tick(); tick();
        check("rst_start",   32'(cpu.start),   0);
        check("rst_resume",  32'(cpu.resume),  0);
        check("rst_led",     32'(cpu.LED),     0);
        check("rst_running", 32'(cpu.running), 0);
        check("rst_paused",  32'(cpu.paused),  0);
        Reset = 1'b1;
        run_count(4);

        // Test 5: DEBOUNCE_CYCLES=4, glitch rejected then long press accepted
        Run4 = 1'b0; tick(); tick(); Run4 = 1'b1;
        run_count(10);
        check("db4_glitch_starts", 32'(n_start4), 0);
        Run4 = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 4) Run4 = 1'b1;
            check("db4_start_early", 32'(cpu4.start), 0);
        end
        tick();
        check("db4_start_edge7", 32'(cpu4.start), 1);
        tick();
        check("db4_start_width", 32'(cpu4.start), 0);
        check("db4_running",     32'(cpu4.running), 1);

        // Test 2: Run low for one cycle -> start on the 4th edge
        Run = 1'b0; tick(); Run = 1'b1;
        check("start_e1", 32'(cpu.start), 0);
        tick(); check("start_e2", 32'(cpu.start), 0);
        tick(); check("start_e3", 32'(cpu.start), 0);
        tick(); check("start_e4", 32'(cpu.start), 1);
        check("start_not_running", 32'(cpu.running), 0);
        tick(); check("start_width", 32'(cpu.start), 0);
        check("running_after_start", 32'(cpu.running), 1);
        // Run again while running is ignored
        Run = 1'b0; tick(); tick(); Run = 1'b1;
        run_count(8);
        check("run_ignored_running", 32'(n_start), 0);
        check("still_running", 32'(cpu.running), 1);

        // Test 3: pause, resume, wait for ack
        cpu.pause_req = 1'b1; cpu.pause_code = 12'h0A5;
        tick();
        check("pause_paused", 32'(cpu.paused), 1);
        check("pause_led",    32'(cpu.LED), 32'h0A5);
        check("pause_not_running", 32'(cpu.running), 0);
        cpu.pause_code = 12'h123;
        Continue = 1'b0; tick(); Continue = 1'b1;
        check("led_held", 32'(cpu.LED), 32'h0A5);
        tick(); check("resume_e2", 32'(cpu.resume), 0);
        tick(); check("resume_e3", 32'(cpu.resume), 0);
        tick(); check("resume_e4", 32'(cpu.resume), 1);
        check("resume_not_paused", 32'(cpu.paused), 0);
        tick(); check("resume_width", 32'(cpu.resume), 0);
        run_count(3);
        check("wait_ack_no_pause", 32'(cpu.paused), 0);
        check("wait_ack_running",  32'(cpu.running), 1);
        cpu.pause_req = 1'b0;
        tick();
        check("ack_running", 32'(cpu.running), 1);
        check("led_kept_after_resume", 32'(cpu.LED), 32'h0A5);
        cpu.pause_req = 1'b1; cpu.pause_code = 12'h3C3;
        tick();
        check("repause_paused", 32'(cpu.paused), 1);
        check("repause_led", 32'(cpu.LED), 32'h3C3);

        // Test 4: Continue held 10 cycles -> one resume
        Continue = 1'b0;
        run_count(10);
        Continue = 1'b1;
        n_chk = n_chk; // keep counts from run_count
        begin
            int r;
            r = n_resume;
            run_count(4);
            check("held_continue_one_resume", 32'(r + n_resume), 1);
        end
        // Immediate re-pause after WAIT_ACK -> RUNNING
        cpu.pause_req = 1'b0; tick();
        check("ack2_running", 32'(cpu.running), 1);
        cpu.pause_req = 1'b1; cpu.pause_code = 12'h0F0;
        tick();
        check("imm_repause", 32'(cpu.paused), 1);
        check("imm_repause_led", 32'(cpu.LED), 32'h0F0);

        // Test 6a: reset with Run held -> no start until release and re-press
        cpu.pause_req = 1'b0;
        Run = 1'b0; tick(); tick(); tick();
        Reset = 1'b0; tick(); tick();
        check("rst2_paused", 32'(cpu.paused), 0);
        check("rst2_led",    32'(cpu.LED), 0);
        Reset = 1'b1;
        run_count(8);
        check("held_run_no_start", 32'(n_start), 0);
        Run = 1'b1;
        run_count(4);
        // Run and Continue pressed together in IDLE -> start only
        Run = 1'b0; Continue = 1'b0; tick();
        Run = 1'b1; Continue = 1'b1;
        run_count(8);
        check("both_one_start", 32'(n_start), 1);
        check("both_no_resume", 32'(n_resume), 0);
        check("both_running", 32'(cpu.running), 1);

        // Test 6b: reset during PAUSED with Continue held
        cpu.pause_req = 1'b1; cpu.pause_code = 12'h5AA;
        tick();
        check("p6_paused", 32'(cpu.paused), 1);
        Continue = 1'b0; tick();
        Reset = 1'b0; tick(); tick();
        check("p6_rst_paused", 32'(cpu.paused), 0);
        check("p6_rst_led",    32'(cpu.LED), 0);
        check("p6_rst_resume", 32'(cpu.resume), 0);
        Reset = 1'b1;
        cpu.pause_req = 1'b0;
        run_count(8);
        check("p6_held_no_resume", 32'(n_resume), 0);
        Continue = 1'b1;
        run_count(4);
        Run = 1'b0; tick(); Run = 1'b1;
        run_count(6);
        check("p6_restart", 32'(n_start), 1);
        cpu.pause_req = 1'b1; cpu.pause_code = 12'h777;
        tick();
        check("p6_repaused_led", 32'(cpu.LED), 32'h777);
        Continue = 1'b0; tick(); Continue = 1'b1;
        run_count(6);
        check("p6_rearmed_resume", 32'(n_resume), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
